// File: rtl/b2c_5bit_core.sv
// Registered 5-bit two's-complement negator with valid, overflow and zero flags.
// Define B2C_SAT_EN to saturate the -(-16) case to +15 instead of wrapping.
module b2c_5bit_core (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [4:0] B,
    input  logic       neg,
    output logic [4:0] X,
    output logic       out_valid,
    output logic       ovf,
    output logic       zero
);
    localparam int STAGES = 1;

    logic [STAGES:0] vld_pipe;
    logic [4:0]      raw;
    logic [4:0]      x_nxt;
    logic            ovf_nxt;
    logic            zero_nxt;

    assign vld_pipe[0] = in_valid;

    always_comb begin
        raw     = neg ? (~B + 5'd1) : B;
        ovf_nxt = neg & (B == 5'b10000);
`ifdef B2C_SAT_EN
        x_nxt   = ovf_nxt ? 5'b01111 : raw;
`else
        x_nxt   = raw;
`endif
        // zero follows the value actually loaded, so it tracks saturation too
        zero_nxt = (x_nxt == 5'd0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_pipe[STAGES:1] <= '0;
            X                  <= 5'd0;
            ovf                <= 1'b0;
            zero               <= 1'b1;
        end else begin
            vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
            if (in_valid) begin
                X    <= x_nxt;
                ovf  <= ovf_nxt;
                zero <= zero_nxt;
            end
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_b2c_5bit_core.sv
// Self-checking bench for b2c_5bit_core: directed steps plus random stimulus
// against an arithmetic reference model.
module tb_b2c_5bit_core;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [4:0] B = '0;
    logic       neg = 1'b0;
    logic [4:0] X;
    logic       out_valid, ovf, zero;

    int total = 0;
    int bad = 0;

    // reference state
    int m_x = 0;
    int m_ovf = 0;
    int m_zero = 1;
    int m_vld = 0;

    b2c_5bit_core dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .B(B), .neg(neg),
        .X(X), .out_valid(out_valid), .ovf(ovf), .zero(zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic r, input logic v, input int b, input logic n);
        int val;
        rst_n    = r;
        in_valid = v;
        B        = 5'(b);
        neg      = n;
        @(posedge clk);
        if (!r) begin
            m_x = 0; m_ovf = 0; m_zero = 1; m_vld = 0;
        end else begin
            m_vld = v ? 1 : 0;
            if (v) begin
                val   = n ? (32 - b) % 32 : b;
                m_ovf = (n && b == 16) ? 1 : 0;
`ifdef B2C_SAT_EN
                if (m_ovf == 1) val = 15;
`endif
                m_x    = val;
                m_zero = (val == 0) ? 1 : 0;
            end
        end
        #1;
        check({tag, ".X"},    {3'b0, X},         8'(m_x));
        check({tag, ".ovf"},  {7'b0, ovf},       8'(m_ovf));
        check({tag, ".zero"}, {7'b0, zero},      8'(m_zero));
        check({tag, ".vld"},  {7'b0, out_valid}, 8'(m_vld));
    endtask

    initial begin
        #2;
        step("rst0", 1'b0, 1'b1, 5, 1'b1);
        step("rst1", 1'b0, 1'b1, 5, 1'b1);

        for (int i = 0; i < 32; i++) step("sweep", 1'b1, 1'b1, i, 1'b1);

        // spot checks with fixed expectations
        step("spot1", 1'b1, 1'b1, 1, 1'b1);
        check("spot1.lit", {3'b0, X}, 8'b0001_1111);
        step("spot7", 1'b1, 1'b1, 7, 1'b1);
        check("spot7.lit", {3'b0, X}, 8'b0001_1001);
        step("spot25", 1'b1, 1'b1, 25, 1'b1);
        check("spot25.lit", {3'b0, X}, 8'b0000_0111);

        step("ovf", 1'b1, 1'b1, 16, 1'b1);
`ifdef B2C_SAT_EN
        check("ovf.lit", {3'b0, X}, 8'd15);
`else
        check("ovf.lit", {3'b0, X}, 8'd16);
`endif
        check("ovf.flag", {7'b0, ovf}, 8'd1);

        step("pass22", 1'b1, 1'b1, 22, 1'b0);
        check("pass22.lit", {3'b0, X}, 8'd22);
        step("pass16", 1'b1, 1'b1, 16, 1'b0);
        step("pass0", 1'b1, 1'b1, 0, 1'b0);

        step("hold.load", 1'b1, 1'b1, 3, 1'b1);
        for (int i = 0; i < 3; i++) step("hold", 1'b1, 1'b0, int'($urandom_range(31)), 1'(i));
        check("hold.lit", {3'b0, X}, 8'd29);

        step("midrst.a", 1'b1, 1'b1, 9, 1'b1);
        step("midrst", 1'b0, 1'b1, 4, 1'b1);
        step("midrst.post", 1'b1, 1'b1, 4, 1'b1);
        check("midrst.lit", {3'b0, X}, 8'd28);

        for (int i = 0; i < 300; i++)
            step("rand", ($urandom_range(19) != 0), 1'($urandom), int'($urandom_range(31)), 1'($urandom));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
